// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper pulse generator: register map, bit indices, FSM states.
package stepper_pkg;

  localparam logic [1:0] AddrCtrl       = 2'd0;
  localparam logic [1:0] AddrHalfPeriod = 2'd1;
  localparam logic [1:0] AddrPosition   = 2'd2;
  localparam logic [1:0] AddrStatus     = 2'd3;

  localparam int unsigned CtrlEnable    = 0;
  localparam int unsigned CtrlHomeStart = 1;
  localparam int unsigned CtrlDirReq    = 2;

  localparam int unsigned StatHomed  = 0;
  localparam int unsigned StatBusy   = 1;
  localparam int unsigned StatSwitch = 2;
  localparam int unsigned StatFault  = 3;

  typedef enum logic [1:0] {StIdle, StRun, StSeek, StLatch} state_e;

  // Nonzero half periods below the minimum are raised to it; zero means "no stepping".
  function automatic logic [23:0] clamp_half_period(input logic [23:0] value,
                                                    input logic [23:0] min_value);
    return (value != '0 && value < min_value) ? min_value : value;
  endfunction

endpackage

// File: rtl/stepper_debounce.sv
// Home switch conditioning: two-flop synchronizer followed by a stability counter.
module stepper_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic switch_raw,
  output logic switch_db
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      db_d  = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], switch_raw};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign switch_db = db_q;

endmodule

// File: rtl/stepper_pulse_gen.sv
// Avalon-MM step/dir pulse generator with signed position count, homing and negative limit stop.
module stepper_pulse_gen
  import stepper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 50000,
  parameter int unsigned HOME_HALF_PERIOD = 5000,
  parameter int unsigned MIN_HALF_PERIOD  = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        step_pin,
  output logic        dir_pin,
  input  logic        home_switch
);

  localparam logic [23:0] HomeHalf = 24'(HOME_HALF_PERIOD);
  localparam logic [23:0] MinHalf  = 24'(MIN_HALF_PERIOD);

  state_e      state_q, state_d;
  logic        step_q, step_d, dir_q, dir_d;
  logic [23:0] cnt_q, cnt_d;
  logic [31:0] pos_q, pos_d;
  logic        homed_q, homed_d, fault_q, fault_d;
  logic        enable_q, dir_req_q, db_prev_q;
  logic [23:0] hp_q;
  logic [31:0] readdata_q, rd_mux;

  logic        switch_db, wr_ctrl, wr_hp, wr_pos, home_start;
  logic        enable_eff, dir_req_eff, db_rise, stalled, stop;
  logic [23:0] hp_eff;
  logic [31:0] step_delta;

  stepper_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset_n   (reset_n),
    .switch_raw(home_switch),
    .switch_db (switch_db)
  );

  assign wr_ctrl    = avs_write && (avs_address == AddrCtrl);
  assign wr_hp      = avs_write && (avs_address == AddrHalfPeriod);
  assign wr_pos     = avs_write && (avs_address == AddrPosition);
  assign home_start = wr_ctrl && avs_writedata[CtrlHomeStart];

  // Same-cycle view of CTRL/HALF_PERIOD so the enabling write itself starts the counter.
  assign enable_eff  = wr_ctrl ? avs_writedata[CtrlEnable] : enable_q;
  assign dir_req_eff = wr_ctrl ? avs_writedata[CtrlDirReq] : dir_req_q;
  assign hp_eff      = wr_hp ? clamp_half_period(avs_writedata[23:0], MinHalf) : hp_q;

  assign db_rise    = switch_db && !db_prev_q;
  assign stop       = !enable_q || (hp_q == '0);
  assign stalled    = !step_q && !dir_q && switch_db;
  assign step_delta = dir_q ? 32'd1 : 32'hFFFF_FFFF;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    homed_d = homed_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: begin
        step_d = 1'b0;
        dir_d  = dir_req_eff;
        if (home_start) begin
          state_d = StSeek;
          dir_d   = 1'b0;
          cnt_d   = HomeHalf - 24'd1;
          homed_d = 1'b0;
        end else if (enable_eff && hp_eff != '0) begin
          state_d = StRun;
          cnt_d   = hp_eff - 24'd1;
        end
      end
      StRun: begin
        if (home_start) begin
          state_d = StSeek;
          cnt_d   = HomeHalf - 24'd1;
          homed_d = 1'b0;
        end else if (!step_q && stop) begin
          state_d = StIdle;
        end else if (stalled) begin
          // Held low at the limit: the motor is stopped, so direction may be reloaded and the
          // low phase restarts, giving a full half period of setup before the next rise.
          fault_d = 1'b1;
          dir_d   = dir_req_eff;
          cnt_d   = hp_q - 24'd1;
        end else if (cnt_q == '0) begin
          step_d = !step_q;
          cnt_d  = hp_q - 24'd1;
          if (!step_q) begin
            pos_d = pos_q + step_delta;
          end else begin
            dir_d = dir_req_eff;
            if (stop) state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      StSeek: begin
        if (db_rise) begin
          state_d = StLatch;
        end else if (cnt_q == '0) begin
          step_d = !step_q;
          cnt_d  = HomeHalf - 24'd1;
          if (!step_q) pos_d = pos_q + step_delta;
          else         dir_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      StLatch: begin
        step_d  = 1'b0;
        pos_d   = '0;
        homed_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (wr_ctrl) fault_d = 1'b0;
    if (wr_pos)  pos_d   = avs_writedata;
  end

  always_comb begin
    rd_mux = '0;
    unique case (avs_address)
      AddrCtrl: begin
        rd_mux[CtrlEnable] = enable_q;
        rd_mux[CtrlDirReq] = dir_req_q;
      end
      AddrHalfPeriod: rd_mux[23:0] = hp_q;
      AddrPosition:   rd_mux = pos_q;
      AddrStatus: begin
        rd_mux[StatHomed]  = homed_q;
        rd_mux[StatBusy]   = (state_q == StSeek) || (state_q == StLatch);
        rd_mux[StatSwitch] = switch_db;
        rd_mux[StatFault]  = fault_q;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      step_q     <= 1'b0;
      dir_q      <= 1'b1;
      cnt_q      <= '0;
      pos_q      <= '0;
      homed_q    <= 1'b0;
      fault_q    <= 1'b0;
      enable_q   <= 1'b0;
      dir_req_q  <= 1'b1;
      hp_q       <= '0;
      db_prev_q  <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      homed_q   <= homed_d;
      fault_q   <= fault_d;
      db_prev_q <= switch_db;
      if (wr_ctrl) begin
        enable_q  <= avs_writedata[CtrlEnable];
        dir_req_q <= avs_writedata[CtrlDirReq];
      end
      if (wr_hp)    hp_q       <= hp_eff;
      if (avs_read) readdata_q <= rd_mux;
    end
  end

  assign avs_readdata = readdata_q;
  assign step_pin     = step_q;
  assign dir_pin      = dir_q;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Directed + randomized bench for stepper_pulse_gen against an arithmetic timing model.
`timescale 1ns/1ns
module tb_stepper_pulse_gen;

  localparam int HH = 20;  // homing half period used by this bench

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        step_pin, dir_pin;
  logic        home_switch = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int rises[$];

  stepper_pulse_gen #(
    .DEBOUNCE_CYCLES (16),
    .HOME_HALF_PERIOD(HH),
    .MIN_HALF_PERIOD (25)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .avs_address  (avs_address),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_read     (avs_read),
    .avs_readdata (avs_readdata),
    .step_pin     (step_pin),
    .dir_pin      (dir_pin),
    .home_switch  (home_switch)
  );

  always #5 clk = ~clk;

  // Clock edge k happens at time 10k-5.
  function automatic int edge_now();
    return int'(($time + 5) / 10);
  endfunction

  always @(posedge step_pin) rises.push_back(edge_now());

  // Rising edges in the first t clocks after stepping starts with half period h.
  function automatic int n_rises(input int t, input int h);
    return (t < h) ? 0 : (t - h) / (2 * h) + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1 avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1 avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_edge(input int e);
    while (edge_now() < e) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] d, p0, x, lo;
    int w, t2, f, e, h, n, r, first, bad, cnt0;
    logic seen, found;

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check("reset_step", 32'(step_pin), 32'd0);
    check("reset_dir", 32'(dir_pin), 32'd1);
    rd(2'd0, d); check("reset_ctrl", d, 32'h4);
    rd(2'd1, d); check("reset_hp", d, 32'h0);
    rd(2'd2, d); check("reset_pos", d, 32'h0);
    rd(2'd3, d); check("reset_status", d, 32'h0);

    // Half-period register: clamping and 24-bit width
    r = $urandom_range(1, 24);
    wr(2'd1, 32'(r)); rd(2'd1, d); check("hp_clamp", d, 32'd25);
    wr(2'd1, 32'd0); rd(2'd1, d); check("hp_zero", d, 32'd0);
    x = $urandom; lo = x & 32'h00FF_FFFF;
    wr(2'd1, x); rd(2'd1, d);
    check("hp_rand", d, (lo != 0 && lo < 25) ? 32'd25 : lo);
    p0 = $urandom;
    wr(2'd2, p0); rd(2'd2, d); check("pos_load", d, p0);
    wr(2'd2, 32'd0);

    // Main run: 100-clock half period, positive direction
    wr(2'd1, 32'd100);
    rises.delete();
    wr(2'd0, 32'h5); w = edge_now();
    wait_edge(w + 10000);
    check("run_rises", 32'(rises.size()), 32'd50);
    check("run_first", 32'((rises.size() > 0) ? rises[0] - w : -1), 32'd100);
    bad = 0;
    for (int i = 1; i < rises.size(); i++) if (rises[i] - rises[i-1] != 200) bad++;
    check("run_period", 32'(bad), 32'd0);
    rd(2'd2, d); check("run_pos", d, 32'd50);
    rd(2'd0, d); check("run_ctrl", d, 32'h5);

    // Direction change only on a falling edge
    r = $urandom_range(1, 150);
    wait_edge(w + 10000 + r - 1);
    wr(2'd0, 32'h1); t2 = edge_now() - w;
    f = ((t2 + 199) / 200) * 200;
    wait_edge(w + f - 1);
    check("dir_before_fall", 32'(dir_pin), 32'd1);
    wait_edge(w + f);
    check("dir_after_fall", 32'(dir_pin), 32'd0);
    check("step_after_fall", 32'(step_pin), 32'd0);
    e = f + 2000;
    wait_edge(w + e - 1);
    check("rev_rises", 32'(rises.size()), 32'(n_rises(e - 1, 100)));
    rd(2'd2, d);
    check("rev_pos", d, 32'(2 * n_rises(f, 100) - n_rises(e - 1, 100)));

    // Disable: must come to rest
    wr(2'd0, 32'h0);
    wait_edge(edge_now() + 400);
    cnt0 = rises.size();
    wait_edge(edge_now() + 400);
    check("stop_no_rises", 32'(rises.size()), 32'(cnt0));
    check("stop_step_low", 32'(step_pin), 32'd0);

    // Randomized rates and start positions
    for (int it = 0; it < 3; it++) begin
      p0 = $urandom; h = $urandom_range(25, 60); n = $urandom_range(300, 800);
      wr(2'd2, p0); wr(2'd1, 32'(h));
      rises.delete();
      wr(2'd0, 32'h5); w = edge_now();
      wait_edge(w + n);
      check("rand_rises", 32'(rises.size()), 32'(n_rises(n, h)));
      rd(2'd2, d);
      check("rand_pos", d, p0 + 32'(n_rises(n, h)));
      wr(2'd0, 32'h4);
      wait_edge(edge_now() + 2 * h + 4);
    end

    // Debounce: a short glitch is ignored
    rd(2'd3, d); check("status_idle", d, 32'h0);
    home_switch = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    home_switch = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin rd(2'd3, d); seen |= d[2]; end
    check("glitch_ignored", 32'(seen), 32'd0);

    // Debounce: steady level accepted after sync + 16 stable cycles
    home_switch = 1'b1; w = edge_now(); first = -1;
    for (int i = 0; i < 40; i++) begin
      rd(2'd3, d);
      if (d[2] && first < 0) first = edge_now();
    end
    check("db_latency", 32'(first - w), 32'd19);
    home_switch = 1'b0;
    wait_edge(edge_now() + 40);
    rd(2'd3, d); check("db_release", d, 32'h0);

    // Homing
    wr(2'd2, 32'd1000);
    rises.delete();
    wr(2'd0, 32'h2); w = edge_now();
    check("home_dir", 32'(dir_pin), 32'd0);
    rd(2'd3, d); check("home_busy", d, 32'h2);
    wait_edge(w + 260);
    check("home_steps", 32'(rises.size()), 32'd7);
    home_switch = 1'b1;
    rd(2'd2, d); check("home_pos_seek", d, 32'd993);
    wait_edge(w + 279);
    rd(2'd2, d); check("home_pos_latch", d, 32'd993);
    rd(2'd2, d); check("home_pos_zero", d, 32'd0);
    rd(2'd3, d); check("home_status", d, 32'h5);
    check("home_step_low", 32'(step_pin), 32'd0);
    check("home_no_extra", 32'(rises.size()), 32'd7);

    // Negative limit with switch active
    wr(2'd1, 32'd30);
    rises.delete();
    wr(2'd0, 32'h1); w = edge_now();
    wait_edge(w + 100);
    check("limit_no_rises", 32'(rises.size()), 32'd0);
    rd(2'd3, d); check("limit_fault", d, 32'hD);
    wr(2'd0, 32'h5); w = edge_now();
    rd(2'd3, d); check("limit_cleared", d, 32'h5);
    wait_edge(w + 200);
    check("resume_first", 32'((rises.size() > 0) ? rises[0] - w : -1), 32'd30);
    check("resume_rises", 32'(rises.size()), 32'(n_rises(200, 30)));
    check("resume_dir", 32'(dir_pin), 32'd1);
    rd(2'd2, d); check("resume_pos", d, 32'd3);

    // Asynchronous reset while step is high
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      found = step_pin;
    end
    check("found_high", 32'(found), 32'd1);
    home_switch = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_step", 32'(step_pin), 32'd0);
    check("async_dir", 32'(dir_pin), 32'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    rd(2'd2, d); check("post_reset_pos", d, 32'd0);
    rd(2'd0, d); check("post_reset_ctrl", d, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
